// File: rtl/cmp_share_pkg.sv
// Shared types and defaults for the compare-sharing arbiter.
// Optional build macro CMP_SIGNED_EN selects a signed compare in cmp_core.
package cmp_share_pkg;

    localparam int unsigned NumReqDefault = 4;
    localparam int unsigned WidthDefault  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StResp
    } state_e;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational WIDTH-bit magnitude comparator.
// With CMP_SIGNED_EN defined, operands are two's-complement; otherwise unsigned.
module cmp_core
    import cmp_share_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    always_comb begin
        res.eq = (a == b);
`ifdef CMP_SIGNED_EN
        res.gt = ($signed(a) > $signed(b));
        res.lt = ($signed(a) < $signed(b));
`else
        res.gt = (a > b);
        res.lt = (a < b);
`endif
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin share of one comparator among NUM_REQ requesters (IDLE -> CMP -> RESP).
// Build macro CMP_SIGNED_EN switches the shared compare to signed operands.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault,
    parameter int unsigned WIDTH   = WidthDefault,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_gt,
    output logic                     rsp_lt,
    output logic                     rsp_eq,
    output logic                     busy
);

    localparam logic [IDW:0]   NumReqW = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LastId  = IDW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    cmp_res_t             res_q, res_d, core_res;
    logic [IDW-1:0]       winner;
    logic                 found;
    logic [IDW:0]         scan;

    // Scan from rr_ptr upward with an explicit wrap so no index >= NUM_REQ is produced.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        scan   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            scan = {1'b0, rr_ptr_q} + (IDW+1)'(off);
            if (scan >= NumReqW) begin
                scan = scan - NumReqW;
            end
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found  = 1'b1;
                winner = scan[IDW-1:0];
            end
        end
    end

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_cmp_core (
        .a   (a_q),
        .b   (b_q),
        .res (core_res)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        rsp_id_d    = rsp_id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        rsp_valid_d = '0;
        req_ready   = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready  = NUM_REQ'(1) << winner;
                    a_d        = req_a[winner*WIDTH +: WIDTH];
                    b_d        = req_b[winner*WIDTH +: WIDTH];
                    grant_id_d = winner;
                    state_d    = StCmp;
                end
            end
            StCmp: begin
                res_d       = core_res;
                rsp_id_d    = grant_id_q;
                rsp_valid_d = NUM_REQ'(1) << grant_id_q;
                state_d     = StResp;
            end
            StResp: begin
                rr_ptr_d = (grant_id_q == LastId) ? '0 : grant_id_q + IDW'(1);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            rsp_id_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            rsp_id_q    <= rsp_id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = res_q.gt;
    assign rsp_lt    = res_q.lt;
    assign rsp_eq    = res_q.eq;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed scenarios plus random traffic against a
// cycle-timeline model (grant at cycle n -> result at n+2, arbiter free at n+3).
module tb_cmp_share_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   rsp_valid;
    logic [1:0]     rsp_id;
    logic           rsp_gt, rsp_lt, rsp_eq, busy;

    always #5 clk = ~clk;

    cmp_share_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: pointer, first cycle the arbiter is free, one outstanding result.
    int m_ptr     = 0;
    int m_free_at = 0;
    int m_win;
    bit p_on      = 1'b0;
    int p_due, p_id;
    bit [2:0] p_res;

    // Driver state: operands held by each requester until it is accepted.
    logic [N-1:0]   hv = '0;
    logic [N*W-1:0] ha = '0;
    logic [N*W-1:0] hb = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int sval(input int v);
`ifdef CMP_SIGNED_EN
        return (v >= 8) ? v - 16 : v;
`else
        return v;
`endif
    endfunction

    task automatic run_cycle(input logic rst, input logic [N-1:0] v,
                             input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [N-1:0] exp_ready, exp_rsp;
        bit due;
        int sa, sb;
        rst_n     = rst;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        m_win = -1;
        if (!rst) begin
            p_on      = 1'b0;
            m_ptr     = 0;
            m_free_at = 0;
        end else if (cyc >= m_free_at) begin
            for (int k = 0; k < N; k++) begin
                if (v[(m_ptr + k) % N]) begin
                    m_win = (m_ptr + k) % N;
                    break;
                end
            end
        end
        exp_ready = (m_win >= 0) ? N'(1) << m_win : '0;
        due       = p_on && (p_due == cyc);
        exp_rsp   = due ? N'(1) << p_id : '0;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("busy", busy, rst && (cyc < m_free_at));
        check_eq("rsp_valid", rsp_valid, exp_rsp);
        check_eq("ready_onehot0", $onehot0(req_ready), 1);
        check_eq("rsp_onehot0", $onehot0(rsp_valid), 1);
        if (rsp_valid != '0) begin
            check_eq("res_onehot", $onehot({rsp_gt, rsp_lt, rsp_eq}), 1);
        end
        if (due) begin
            check_eq("rsp_id", rsp_id, p_id);
            check_eq("rsp_gt_lt_eq", {rsp_gt, rsp_lt, rsp_eq}, p_res);
            p_on = 1'b0;
        end
        if (!rst) begin
            check_eq("rst_rsp_id", rsp_id, 0);
            check_eq("rst_res", {rsp_gt, rsp_lt, rsp_eq}, 0);
        end
        if (m_win >= 0) begin
            sa        = sval(int'(a[m_win*W +: W]));
            sb        = sval(int'(b[m_win*W +: W]));
            p_res     = {sa > sb, sa < sb, sa == sb};
            p_on      = 1'b1;
            p_due     = cyc + 2;
            p_id      = m_win;
            m_free_at = cyc + 3;
            m_ptr     = (m_win + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        hv[i]         = 1'b1;
        ha[i*W +: W]  = a;
        hb[i*W +: W]  = b;
    endtask

    // One cycle of held requests; an accepted requester drops its valid.
    task automatic tick();
        run_cycle(1'b1, hv, ha, hb);
        if (m_win >= 0) hv[m_win] = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1;
        run_cycle(1'b0, '0, '0, '0);
        run_cycle(1'b0, '0, '0, '0);

        // Single request from requester 0: 1 > 0.
        post(0, 4'h1, 4'h0);
        drain(5);

        // All four held with A=B=A: grants 0,1,2,3,0 three cycles apart.
        for (int i = 0; i < 15; i++) run_cycle(1'b1, 4'b1111, {4{4'hA}}, {4{4'hA}});
        drain(3);

        // Advance pointer to 2, then 1 and 3 contend: 3 first, then 1.
        post(1, 4'h5, 4'h5);
        drain(4);
        post(1, 4'h8, 4'h7);
        post(3, 4'h2, 4'h3);
        drain(8);

        // Boundary operands.
        post(2, 4'hF, 4'hE);
        drain(4);
        post(0, 4'h0, 4'h0);
        drain(4);
        post(3, 4'h6, 4'h9);
        drain(4);
        post(1, 4'hF, 4'hF);
        drain(4);

        // Reset while in CMP: result discarded, requester 0 wins afterwards.
        post(2, 4'h3, 4'h1);
        tick();
        run_cycle(1'b0, hv, ha, hb);
        for (int i = 0; i < N; i++) post(i, W'(i), 4'h2);
        drain(14);

        // Random traffic with occasional withdrawal before grant.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hv[i] && ($urandom_range(0, 3) == 0)) begin
                    post(i, W'($urandom), W'($urandom));
                end else if (hv[i] && ($urandom_range(0, 15) == 0)) begin
                    hv[i] = 1'b0;
                end
            end
            tick();
        end
        hv = '0;
        drain(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
Shares one 4-bit magnitude-comparator datapath between NUM_REQ requesters. A round-robin arbiter grants one request at a time and registers its operands. The shared compare runs on those registered operands, and the gt/lt/eq result returns to the granted requester. The block sits between multiple compare clients and a single comparator core.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
WIDTH, 4, operand width in bits.
IDW, $clog2(NUM_REQ), width of the requester index.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
req_a  input  NUM_REQ*WIDTH  flattened A operands; requester i is at [i*WIDTH +: WIDTH].
req_b  input  NUM_REQ*WIDTH  flattened B operands, same packing.
rsp_valid  output  NUM_REQ  one-hot result strobe to the owning requester.
rsp_id  output  IDW  index of the requester owning the current result.
rsp_gt  output  1  A > B.
rsp_lt  output  1  A < B.
rsp_eq  output  1  A == B.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, rr_ptr=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_gt/lt/eq=0, busy=0. req_ready is combinational and 0 while rst_n is low.
- FSM states: IDLE -> CMP -> RESP -> IDLE.
- IDLE, arbitration:
  - If any req_valid is high, pick the first set bit scanning from rr_ptr upward, wrapping past NUM_REQ-1 to 0.
  - Drive req_ready[winner]=1 combinationally in the same cycle. Handshake = req_valid & req_ready.
  - On that edge, capture req_a/req_b of the winner and its index into grant_id, then go to CMP.
  - With no request: stay in IDLE, all req_ready=0.
- CMP:
  - Comparator core evaluates the registered operands.
  - gt/lt/eq and grant_id are registered into the rsp_* regs; go to RESP.
  - req_ready=0 for all requesters.
- RESP:
  - rsp_valid[grant_id]=1 for exactly one cycle; rsp_id=grant_id.
  - rsp_gt/lt/eq hold their values until the next RESP; they are meaningful only while rsp_valid is high.
  - rr_ptr <= (grant_id==NUM_REQ-1) ? 0 : grant_id+1.
  - Go to IDLE. There is no response backpressure.
- Latency and throughput:
  - Accept edge T -> rsp_valid high during cycle T+2.
  - Max throughput is one compare per 3 cycles.
  - Starvation bound: a requester holding valid is granted within NUM_REQ grants.
- Result encoding: exactly one of gt/lt/eq is high during rsp_valid. Unsigned compare by default.
- Boundary conditions:
  - Simultaneous requests: only the round-robin winner sees ready. Losers must hold valid and operands stable until accepted.
  - Requester deasserts valid before being granted: no effect; it is simply not selected.
  - A granted requester may re-request the cycle after RESP. It then has the lowest priority relative to the others.
  - Non-power-of-two NUM_REQ: the pointer wraps explicitly and never indexes a requester >= NUM_REQ.
  - Reset mid-operation (CMP or RESP): return to IDLE immediately; any pending result is discarded with no rsp_valid; rr_ptr=0.
  - Operands: all 2^WIDTH values are legal, including 0 vs 0 and max vs max.

Optional Feature:
CMP_SIGNED_EN:
- Defined: operands are compared as two's-complement signed values. The eq output is unaffected.
- Undefined: unsigned magnitude compare.

Decomposition:
- Package cmp_share_pkg:
  - state enum (IDLE, CMP, RESP);
  - default NUM_REQ/WIDTH constants;
  - result struct {gt, lt, eq}.
- Sub-module cmp_core: purely combinational WIDTH-bit comparator. It honours CMP_SIGNED_EN and is instantiated once.
- Arbiter, FSM and registers live in the top module.

Test Plan:
1. Reset, then one request: requester 0 issues A=4'h1, B=4'h0. Expect req_ready[0] in the same cycle; 2 cycles later rsp_valid=4'b0001, gt=1, lt=0, eq=0, rsp_id=0.
2. All four valid together with A=B=4'hA, held continuously. Expect grants in order 0,1,2,3,0, each result eq=1, and rsp_valid strobes spaced 3 cycles apart.
3. Requesters 1 and 3 valid with rr_ptr=2: requester 3 wins first (A=4'h2, B=4'h3 -> lt=1), then requester 1. Requester 1 starts valid with A=4'h8, B=4'h7 and sees no ready until requester 3 completes. It then returns gt=1 unsigned; with CMP_SIGNED_EN, lt=1.
4. Boundary operands: 4'hF vs 4'hE -> gt; 4'h0 vs 4'h0 -> eq; 4'h6 vs 4'h9 -> lt unsigned, gt with CMP_SIGNED_EN.
5. Assert rst_n low during CMP. Expect no rsp_valid, busy=0, state=IDLE, and after release requester 0 is granted first.
6. Throughout every run: req_ready is one-hot or zero, rsp_valid is one-hot or zero, and exactly one of gt/lt/eq is set whenever rsp_valid is high.
